// File: rtl/md_sched.sv
// md_sched: issue/hazard controller for the multi-cycle multiply/divide unit
module md_sched #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_valid,
    input  logic       e_flush,
    input  logic [2:0] e_mdcls,
    input  logic       d_md_use,
    output logic       start,
    output logic [1:0] mdop,
    output logic       ifmsub,
    output logic       regwritemd,
    output logic       mthi,
    output logic       mtlo,
    output logic       busy,
    output logic       stall,
    output logic       done,
    output logic       drop_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_LAT - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             acc, idle, run, is_op, is_div;

    // Decode the E-stage class into unit pulses; every output is forced low while reset is held
    always_comb begin
        acc        = e_valid & ~e_flush & (e_mdcls != 3'd0);
        is_op      = (e_mdcls != 3'd0) & (e_mdcls <= 3'd5);
        is_div     = (e_mdcls == 3'd2) | (e_mdcls == 3'd4);
        idle       = reset & (state_q == IDLE);
        run        = reset & (state_q == RUN);
        start      = idle & acc & is_op;
        mdop       = ~start ? 2'b00 :
                     e_mdcls == 3'd2 ? 2'b01 :
                     e_mdcls == 3'd4 ? 2'b11 :
                     e_mdcls == 3'd1 ? 2'b00 : 2'b10;
        ifmsub     = start & (e_mdcls == 3'd5);
        regwritemd = idle & acc & ~is_op;
        mthi       = regwritemd & (e_mdcls == 3'd6);
        mtlo       = regwritemd & (e_mdcls == 3'd7);
        done       = run & (cnt_q == CNT_W'(1));
        busy       = start | run;
        stall      = d_md_use & busy & ~done;
        drop_err   = reset & drop_q;
        state_d    = start ? RUN : done ? IDLE : state_q;
        cnt_d      = start ? (is_div ? DIV_N : MULT_N) : run ? cnt_q - CNT_W'(1) : cnt_q;
        drop_d     = drop_q | (run & acc);
    end

    // State, countdown and sticky drop flag; an in-flight op is abandoned on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // The countdown must reach done before it could hit zero in RUN
    assert property (@(posedge clk) disable iff (!reset) state_q == RUN |-> cnt_q != '0);
endmodule
